param_add_accum: RTL and testbench



---
 rtl/param_add_accum_pkg.sv | 18 +
 rtl/param_add_accum_if.sv | 38 +++
 rtl/param_add_accum_core.sv | 21 ++
 rtl/param_add_accum.sv | 116 +++++++++++
 tb/tb_param_add_accum.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/param_add_accum_pkg.sv
// ============================================================================
// param_add_pkg : mode encoding shared by the adder/accumulator slice
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package param_add_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD    = 2'b00;
  localparam mode_t MODE_ACC    = 2'b01;
  localparam mode_t MODE_CLR    = 2'b10;
  localparam mode_t MODE_SATADD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/param_add_accum_if.sv
// ============================================================================
// param_add_accum_if : operand input and result output handshake bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_add_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  import param_add_pkg::*;

  logic             in_valid;
  logic             in_ready;
  mode_t            mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sat;
  logic [CNT_W-1:0] acc_cnt;

  modport master (
    output in_valid, mode, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, sat, acc_cnt
  );

  modport slave (
    input  in_valid, mode, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, sat, acc_cnt
  );

endinterface

`default_nettype wire

// File: rtl/param_add_accum_core.sv
// ============================================================================
// add_carry_core : combinational WIDTH-bit a + b + cin giving {cout, s}
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module add_carry_core #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  input  wire logic             cin_i,
  output logic      [WIDTH-1:0] s_o,
  output logic                  cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

`default_nettype wire

// File: rtl/param_add_accum.sv
// ============================================================================
// param_add_accum : adder/accumulator with carry, saturation and handshake
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module param_add_accum
  import param_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  param_add_accum_if.slave   bus
);

  localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fire;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] add_s;
  logic             add_c;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign fire         = bus.in_valid && bus.in_ready;

  // One adder serves both paths: ACC feeds the accumulator in place of a, and a in place of b.
  always_comb begin
    op_a = bus.a;
    op_b = bus.b;
    if (bus.mode == MODE_ACC) begin
      op_a = acc_q;
      op_b = bus.a;
    end
  end

  add_carry_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (bus.cin),
    .s_o    (add_s),
    .cout_o (add_c)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    sat_d       = sat_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (fire) begin
      out_valid_d = 1'b1;
      sum_d       = add_s;
      cout_d      = add_c;
      sat_d       = 1'b0;
      unique case (bus.mode)
        MODE_ADD: ;
        MODE_ACC: begin
          acc_d = add_s;
          cnt_d = cnt_q + 1'b1;
        end
        MODE_CLR: begin
          acc_d  = '0;
          cnt_d  = '0;
          sum_d  = '0;
          cout_d = 1'b0;
        end
        MODE_SATADD: begin
          if (add_c) begin
            sum_d = C_ALL_ONES;
            sat_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      sat_q       <= sat_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.sat       = sat_q;
  assign bus.acc_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_param_add_accum.sv
// ============================================================================
// tb_param_add_accum : directed + randomized checks against a behavioural model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_add_accum;
  import param_add_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  param_add_accum_if #(.WIDTH(8), .CNT_W(4)) bus ();

  param_add_accum #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] sum;
    logic       c;
    logic       s;
    logic [7:0] acc;
    logic [3:0] cnt;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t step(mstate_t cur, logic r, logic iv, logic [1:0] md,
                                   logic [7:0] a, logic [7:0] b, logic ci, logic ordy);
    mstate_t n = cur;
    int      t;
    if (r) return '0;
    if (iv && (!cur.v || ordy)) begin
      n.v = 1'b1;
      n.s = 1'b0;
      case (md)
        2'b00: begin t = a + b + ci; n.sum = t[7:0]; n.c = (t > 255); end
        2'b11: begin
          t = a + b + ci;
          n.c = (t > 255);
          n.sum = n.c ? 8'hFF : t[7:0];
          n.s = n.c;
        end
        2'b01: begin
          t = cur.acc + a + ci;
          n.sum = t[7:0]; n.c = (t > 255); n.acc = t[7:0];
          n.cnt = (cur.cnt == 4'd15) ? 4'd0 : cur.cnt + 4'd1;
        end
        default: begin n.sum = 8'h00; n.c = 1'b0; n.acc = 8'h00; n.cnt = 4'd0; end
      endcase
    end else if (cur.v && ordy) begin
      n.v = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step(m, rst, bus.in_valid, bus.mode, bus.a, bus.b, bus.cin, bus.out_ready);
    started <= 1'b1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("m_out_valid", bus.out_valid, m.v);
      chk("m_in_ready", bus.in_ready, !m.v || bus.out_ready);
      chk("m_acc_cnt", bus.acc_cnt, m.cnt);
      if (m.v) begin
        chk("m_sum", bus.sum, m.sum);
        chk("m_cout", bus.cout, m.c);
        chk("m_sat", bus.sat, m.s);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic iv, logic [1:0] md, logic [7:0] a, logic [7:0] b,
                       logic ci, logic ordy);
    bus.in_valid  = iv;
    bus.mode      = md;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = ci;
    bus.out_ready = ordy;
  endtask

  task automatic expect_out(string name, logic [7:0] s, logic c, logic st, logic [3:0] cnt);
    chk({name, "_valid"}, bus.out_valid, 1'b1);
    chk({name, "_sum"}, bus.sum, s);
    chk({name, "_cout"}, bus.cout, c);
    chk({name, "_sat"}, bus.sat, st);
    chk({name, "_cnt"}, bus.acc_cnt, cnt);
  endtask

  initial begin
    drive(1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 8'h00);
    chk("rst_acc_cnt", bus.acc_cnt, 4'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;

    drive(1'b1, MODE_ADD, 8'hF0, 8'h20, 1'b1, 1'b1);    cyc(); expect_out("add", 8'h11, 1'b1, 1'b0, 4'd0);
    drive(1'b1, MODE_SATADD, 8'hF0, 8'h20, 1'b1, 1'b1); cyc(); expect_out("sat1", 8'hFF, 1'b1, 1'b1, 4'd0);
    drive(1'b1, MODE_SATADD, 8'h10, 8'h01, 1'b0, 1'b1); cyc(); expect_out("sat0", 8'h11, 1'b0, 1'b0, 4'd0);

    drive(1'b1, MODE_ACC, 8'h80, 8'h5A, 1'b0, 1'b1); cyc(); expect_out("acc1", 8'h80, 1'b0, 1'b0, 4'd1);
    drive(1'b1, MODE_ACC, 8'h80, 8'hA5, 1'b0, 1'b1); cyc(); expect_out("acc2", 8'h00, 1'b1, 1'b0, 4'd2);
    drive(1'b1, MODE_ACC, 8'h05, 8'h33, 1'b0, 1'b1); cyc(); expect_out("acc3", 8'h05, 1'b0, 1'b0, 4'd3);
    drive(1'b1, MODE_CLR, 8'h77, 8'h77, 1'b1, 1'b1); cyc(); expect_out("clr", 8'h00, 1'b0, 1'b0, 4'd0);
    drive(1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0, 1'b1); cyc();
    chk("retire_valid", bus.out_valid, 1'b0);

    // Back-pressure: held result, blocked ACC must not touch the accumulator.
    drive(1'b1, MODE_ADD, 8'h01, 8'h02, 1'b0, 1'b0); cyc(); expect_out("bp_first", 8'h03, 1'b0, 1'b0, 4'd0);
    drive(1'b1, MODE_ACC, 8'h33, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", bus.in_ready, 1'b0);
      cyc();
      expect_out("bp_hold", 8'h03, 1'b0, 1'b0, 4'd0);
    end
    drive(1'b1, MODE_ADD, 8'h04, 8'h05, 1'b0, 1'b1); cyc(); expect_out("bp_replace", 8'h09, 1'b0, 1'b0, 4'd0);
    drive(1'b1, MODE_ACC, 8'h00, 8'h00, 1'b0, 1'b1); cyc(); expect_out("bp_acc_kept", 8'h00, 1'b0, 1'b0, 4'd1);

    // Counter wrap, then reset while a result is stalled.
    drive(1'b1, MODE_CLR, 8'h00, 8'h00, 1'b0, 1'b1); cyc();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, MODE_ACC, 8'h01, 8'h00, 1'b0, 1'b1); cyc();
    end
    expect_out("wrap", 8'h10, 1'b0, 1'b0, 4'd0);
    drive(1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0, 1'b0); cyc();
    chk("stall_valid", bus.out_valid, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_cnt", bus.acc_cnt, 4'd0);
    drive(1'b1, MODE_ACC, 8'h00, 8'h00, 1'b0, 1'b1); cyc(); expect_out("midrst_acc", 8'h00, 1'b0, 1'b0, 4'd1);

    // Randomized phase, checked by the model process.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            8'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    drive(1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
